// File: rtl/ripple_checker_if.sv
// Monitor-side bundle for ripple_checker: the sampled counter stream
// (cnt_in, cnt_en) and the checker's lock, error and statistics outputs.
interface ripple_checker_if #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
);
    logic [WIDTH-1:0]  cnt_in;
    logic              cnt_en;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic [STAT_W-1:0] err_count;
    logic [STAT_W-1:0] wrap_count;
    logic [WIDTH-1:0]  last_bad;

    modport master (
        output cnt_in, cnt_en,
        input  locked, err_pulse, err_sticky, err_count, wrap_count, last_bad
    );

    modport slave (
        input  cnt_in, cnt_en,
        output locked, err_pulse, err_sticky, err_count, wrap_count, last_bad
    );
endinterface

// File: rtl/ripple_checker.sv
// Locks onto a free-running up counter and flags every non-increment step.
// Optional macro RIPPLE_CHK_STALL_EN: a held value (cnt_in==prev) is accepted as valid.
module ripple_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int STAT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    ripple_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t            state;
    logic [WIDTH-1:0]  prev;
    logic [3:0]        good_steps;
    logic              locked_q;
    logic              err_pulse_q;
    logic              err_sticky_q;
    logic [STAT_W-1:0] err_count_q;
    logic [STAT_W-1:0] wrap_count_q;
    logic [WIDTH-1:0]  last_bad_q;

    logic [WIDTH-1:0]  prev_inc;
    logic [3:0]        steps_inc;
    logic              step_ok;
    logic              hold_ok;

    assign prev_inc  = prev + 1'b1;
    assign steps_inc = good_steps + 4'd1;
    assign step_ok   = (bus.cnt_in == prev_inc);
`ifdef RIPPLE_CHK_STALL_EN
    assign hold_ok   = (bus.cnt_in == prev);
`else
    assign hold_ok   = 1'b0;
`endif

    // NOTE: every register in this block uses <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prev         <= '0;
            good_steps   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            last_bad_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (!bus.cnt_en) begin
                state    <= IDLE;
                locked_q <= 1'b0;
            end else begin
                prev <= bus.cnt_in;
                case (state)
                    IDLE: begin
                        good_steps <= '0;
                        state      <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (step_ok) begin
                            good_steps <= steps_inc;
                            if (steps_inc == LOCK_TGT) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (!hold_ok) begin
                            good_steps <= '0;
                        end
                    end
                    LOCKED: begin
                        if (step_ok) begin
                            // prev all ones plus a valid step means cnt_in wrapped to zero
                            if (prev == '1 && wrap_count_q != '1)
                                wrap_count_q <= wrap_count_q + 1'b1;
                        end else if (!hold_ok) begin
                            err_pulse_q  <= 1'b1;
                            err_sticky_q <= 1'b1;
                            if (err_count_q != '1)
                                err_count_q <= err_count_q + 1'b1;
                            last_bad_q   <= bus.cnt_in;
                            good_steps   <= '0;
                            locked_q     <= 1'b0;
                            state        <= ACQUIRE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.last_bad   = last_bad_q;
endmodule

// File: tb/tb_ripple_checker.sv
// Self-checking bench for ripple_checker: directed tables, corner sequences and
// randomized streams compared against a sample-history reference model.
module tb_ripple_checker;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int MODULUS  = 1 << WIDTH;
`ifdef RIPPLE_CHK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk;
    logic rst;

    ripple_checker_if #(.WIDTH(WIDTH), .STAT_W(8)) bus ();
    ripple_checker_if #(.WIDTH(WIDTH), .STAT_W(2)) bus_sat ();

    ripple_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ripple_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the current base sample, the run of correct steps
    // since that base, and the unbounded statistics (saturation applied on compare).
    bit m_base, m_lk, m_pulse, m_sticky;
    int m_prev, m_run, m_errs, m_wraps, m_bad;

    function automatic void mdl_reset();
        m_base = 0; m_lk = 0; m_pulse = 0; m_sticky = 0;
        m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0; m_bad = 0;
    endfunction

    function automatic void mdl_edge(input bit en, input int v);
        bit ok, hold;
        m_pulse = 0;
        if (!en) begin
            m_base = 0;
            m_lk   = 0;
            return;
        end
        if (!m_base) begin
            m_base = 1;
            m_run  = 0;
            m_prev = v;
            return;
        end
        ok   = (v == (m_prev + 1) % MODULUS);
        hold = STALL && (v == m_prev);
        if (m_lk) begin
            if (ok) begin
                if (m_prev == MODULUS - 1) m_wraps++;
            end else if (!hold) begin
                m_pulse = 1; m_sticky = 1; m_errs++; m_bad = v;
                m_lk = 0; m_run = 0;
            end
        end else begin
            if (ok) begin
                m_run++;
                if (m_run >= LOCK_CNT) m_lk = 1;
            end else if (!hold) begin
                m_run = 0;
            end
        end
        m_prev = v;
    endfunction

    function automatic int sat(input int x, input int w);
        int top = (1 << w) - 1;
        return (x > top) ? top : x;
    endfunction

    task automatic compare_model();
        check("locked",     int'(bus.locked),     int'(m_lk));
        check("err_pulse",  int'(bus.err_pulse),  int'(m_pulse));
        check("err_sticky", int'(bus.err_sticky), int'(m_sticky));
        check("err_count",  int'(bus.err_count),  sat(m_errs, 8));
        check("wrap_count", int'(bus.wrap_count), sat(m_wraps, 8));
        check("last_bad",   int'(bus.last_bad),   m_bad);
        check("sat_err_count",  int'(bus_sat.err_count),  sat(m_errs, 2));
        check("sat_wrap_count", int'(bus_sat.wrap_count), sat(m_wraps, 2));
        check("sat_err_pulse",  int'(bus_sat.err_pulse),  int'(m_pulse));
    endtask

    task automatic step(input bit en, input int v);
        @(negedge clk);
        bus.cnt_en     = en;
        bus.cnt_in     = WIDTH'(v);
        bus_sat.cnt_en = en;
        bus_sat.cnt_in = WIDTH'(v);
        @(posedge clk);
        mdl_edge(en, v);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},     int'(bus.locked),     0);
        check({tag, "_err_pulse"},  int'(bus.err_pulse),  0);
        check({tag, "_err_sticky"}, int'(bus.err_sticky), 0);
        check({tag, "_err_count"},  int'(bus.err_count),  0);
        check({tag, "_wrap_count"}, int'(bus.wrap_count), 0);
        check({tag, "_last_bad"},   int'(bus.last_bad),   0);
        check({tag, "_sat_err_count"}, int'(bus_sat.err_count), 0);
    endtask

    typedef struct {
        bit en;
        int v;
        bit lk;
        bit pulse;
        int errs;
        int bad;
    } vec_t;

    initial begin
        vec_t tbl[$];
        bit   any_pulse;
        int   sat_pulses;
        int   v;
        int   last;

        rst = 1'b1;
        bus.cnt_en = 1'b0;  bus.cnt_in = '0;
        bus_sat.cnt_en = 1'b0; bus_sat.cnt_in = '0;
        mdl_reset();
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Lock and wrap: 0..15, 0..8
        any_pulse = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, i % MODULUS);
            if (i >= 2) check("lw_locked", int'(bus.locked), 1);
            if (bus.err_pulse) any_pulse = 1;
        end
        check("lw_wrap_count", int'(bus.wrap_count), 1);
        check("lw_err_count",  int'(bus.err_count), 0);
        check("lw_err_sticky", int'(bus.err_sticky), 0);
        check("lw_no_pulse",   int'(any_pulse), 0);

        // Single skip, then enable drop; expectations worked out by hand
        tbl.push_back('{0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 2, 1, 0, 0, 0});
        tbl.push_back('{1, 3, 1, 0, 0, 0});
        tbl.push_back('{1, 4, 1, 0, 0, 0});
        tbl.push_back('{1, 5, 1, 0, 0, 0});
        tbl.push_back('{1, 9, 0, 1, 1, 9});
        tbl.push_back('{1, 10, 0, 0, 1, 9});
        tbl.push_back('{1, 11, 1, 0, 1, 9});
        tbl.push_back('{1, 12, 1, 0, 1, 9});
        tbl.push_back('{0, 0, 0, 0, 1, 9});
        tbl.push_back('{1, 1, 0, 0, 1, 9});
        tbl.push_back('{1, 2, 0, 0, 1, 9});
        tbl.push_back('{1, 3, 1, 0, 1, 9});
        tbl.push_back('{1, 4, 1, 0, 1, 9});
        tbl.push_back('{1, 5, 1, 0, 1, 9});
        tbl.push_back('{0, 5, 0, 0, 1, 9});
        tbl.push_back('{0, 5, 0, 0, 1, 9});
        tbl.push_back('{1, 12, 0, 0, 1, 9});
        tbl.push_back('{1, 13, 0, 0, 1, 9});
        tbl.push_back('{1, 14, 1, 0, 1, 9});
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v);
            check($sformatf("tbl%0d_locked", i),    int'(bus.locked),    int'(tbl[i].lk));
            check($sformatf("tbl%0d_err_pulse", i), int'(bus.err_pulse), int'(tbl[i].pulse));
            check($sformatf("tbl%0d_err_count", i), int'(bus.err_count), tbl[i].errs);
            check($sformatf("tbl%0d_last_bad", i),  int'(bus.last_bad),  tbl[i].bad);
        end
        check("tbl_err_sticky", int'(bus.err_sticky), 1);

        // Stall: locked stream 2,3,3,4
        step(1'b0, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 3);
        step(1'b1, 3);
        check("stall_pulse",  int'(bus.err_pulse), STALL ? 0 : 1);
        check("stall_locked", int'(bus.locked),    STALL ? 1 : 0);
        check("stall_bad",    int'(bus.last_bad),  STALL ? 9 : 3);
        step(1'b1, 4);
        check("stall_after_locked", int'(bus.locked), STALL ? 1 : 0);

        // Saturation: five skips, each followed by a re-lock
        step(1'b0, 0);
        step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        v = 2;
        sat_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, (v + 3) % MODULUS);
            if (bus_sat.err_pulse) sat_pulses++;
            step(1'b1, (v + 4) % MODULUS);
            if (bus_sat.err_pulse) sat_pulses++;
            step(1'b1, (v + 5) % MODULUS);
            if (bus_sat.err_pulse) sat_pulses++;
            check("sat_relocked", int'(bus_sat.locked), 1);
            v = (v + 5) % MODULUS;
        end
        check("sat_pulses",    sat_pulses, 5);
        check("sat_err_held",  int'(bus_sat.err_count), 3);

        // Randomized stream against the model
        last = v;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit en;
            r  = int'($urandom_range(99));
            en = ($urandom_range(99) < 96);
            if (r < 80)      v = (last + 1) % MODULUS;
            else if (r < 88) v = last;
            else             v = int'($urandom_range(MODULUS - 1));
            step(en, v);
            last = v;
        end

        // Async reset between edges, with nonzero statistics
        step(1'b1, (last + 5) % MODULUS);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_all_zero("async");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 7);
        check("post_reset_locked", int'(bus.locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
